// File: rtl/element_insertion.sv
// Assembles a packed vector from nBits-wide elements written by index or in sequence,
// then presents it with a valid/ready handshake. Optional ELEMENT_INSERTION_DUPCHK_EN enables dup_err.
module element_insertion #(
    parameter int unsigned N     = 100,
    parameter int unsigned nBits = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             wr_indexed,
    input  logic [31:0]      seleccion,
    input  logic [nBits-1:0] in,
    output logic [0:N-1]     vec_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             idx_err,
    output logic             dup_err
);

    localparam int unsigned NELEM = N / nBits;
    localparam int unsigned PTR_W = (NELEM > 1) ? $clog2(NELEM) : 1;

    typedef enum logic {
        S_FILL = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [0:N-1]       r_vec;
    logic [NELEM-1:0]   r_mask;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_idx_err;

    logic               w_accept;
    logic [31:0]        w_tgt;
    logic               w_in_range;
    logic               w_wr_en;
    logic [NELEM-1:0]   w_onehot;
    logic               w_complete;

    // Target decode and completion detect for the current write
    always_comb begin
        w_accept   = wr_valid & (r_state == S_FILL);
        w_tgt      = wr_indexed ? seleccion : 32'(r_ptr);
        w_in_range = (w_tgt < 32'(NELEM));
        w_wr_en    = w_accept & w_in_range & ~clear;
        w_onehot   = '0;
        for (int k = 0; k < int'(NELEM); k++) begin
            if (w_tgt == 32'(k)) begin
                w_onehot[k] = 1'b1;
            end
        end
        w_complete = w_wr_en & (&(r_mask | w_onehot));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_FILL;
        end else begin
            case (r_state)
                S_FILL: if (w_complete) w_state_nxt = S_DONE;
                S_DONE: if (out_ready)  w_state_nxt = S_FILL;
                default: w_state_nxt = S_FILL;
            endcase
        end
    end

    // Vector, written-mask and sequential pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec     <= '0;
            r_mask    <= '0;
            r_ptr     <= '0;
            r_idx_err <= 1'b0;
        end else if (clear) begin
            r_vec     <= '0;
            r_mask    <= '0;
            r_ptr     <= '0;
            r_idx_err <= 1'b0;
        end else begin
            r_idx_err <= w_accept & ~w_in_range;
            if (r_state == S_DONE && out_ready) begin
                r_mask <= '0;
                r_ptr  <= '0;
            end else if (w_wr_en) begin
                for (int k = 0; k < int'(NELEM); k++) begin
                    if (w_onehot[k]) begin
                        r_vec[k*nBits +: nBits] <= in;
                    end
                end
                r_mask <= r_mask | w_onehot;
                if (!wr_indexed) begin
                    r_ptr <= (r_ptr == PTR_W'(NELEM - 1)) ? '0 : r_ptr + PTR_W'(1);
                end
            end
        end
    end

`ifdef ELEMENT_INSERTION_DUPCHK_EN
    logic r_dup_err;

    // Flags a write landing on an element already written in this fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dup_err <= 1'b0;
        end else if (clear) begin
            r_dup_err <= 1'b0;
        end else begin
            r_dup_err <= w_wr_en & (|(r_mask & w_onehot));
        end
    end

    assign dup_err = r_dup_err;
`else
    assign dup_err = 1'b0;
`endif

    assign wr_ready  = (r_state == S_FILL);
    assign out_valid = (r_state == S_DONE);
    assign vec_out   = r_vec;
    assign idx_err   = r_idx_err;

endmodule

// File: tb/tb_element_insertion.sv
// Table-driven bench for element_insertion (N=100, nBits=32, three elements plus 4 pad bits).
module tb_element_insertion;

    localparam int unsigned N  = 100;
    localparam int unsigned NB = 32;
`ifdef ELEMENT_INSERTION_DUPCHK_EN
    localparam bit DUP_ON = 1'b1;
`else
    localparam bit DUP_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          wr_valid;
    logic          wr_ready;
    logic          wr_indexed;
    logic [31:0]   seleccion;
    logic [NB-1:0] d_in;
    logic [0:N-1]  vec_out;
    logic          out_valid;
    logic          out_ready;
    logic          idx_err;
    logic          dup_err;

    element_insertion #(.N(N), .nBits(NB)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_indexed(wr_indexed),
        .seleccion(seleccion), .in(d_in), .vec_out(vec_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .idx_err(idx_err), .dup_err(dup_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wv, idx;
        logic [31:0] sel, d;
        logic        clr, ordy;
        logic        rdy, ov, ie, dup_if;
        logic [31:0] e0, e1, e2;
    } vec_t;

    typedef struct {
        logic        rdy, ov, ie, de;
        logic [31:0] e0, e1, e2;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   step   = 0;

    function automatic vec_t mk(logic wv, logic idx, logic [31:0] sel, logic [31:0] d,
                                logic clr, logic ordy, logic rdy, logic ov, logic ie,
                                logic dup_if, logic [31:0] e0, logic [31:0] e1, logic [31:0] e2);
        vec_t v;
        v.wv = wv; v.idx = idx; v.sel = sel; v.d = d; v.clr = clr; v.ordy = ordy;
        v.rdy = rdy; v.ov = ov; v.ie = ie; v.dup_if = dup_if;
        v.e0 = e0; v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    function automatic logic [31:0] elem(logic [0:N-1] v, int k);
        return v[k*NB +: NB];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", name, step, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        exp_t e;
        logic [3:0] pad;
        wr_valid   = v.wv;
        wr_indexed = v.idx;
        seleccion  = v.sel;
        d_in       = v.d;
        clear      = v.clr;
        out_ready  = v.ordy;
        sb.push_back('{rdy: v.rdy, ov: v.ov, ie: v.ie, de: v.dup_if & DUP_ON,
                       e0: v.e0, e1: v.e1, e2: v.e2});
        @(posedge clk);
        #1;
        step++;
        e   = sb.pop_front();
        pad = vec_out[96:99];
        check("wr_ready",  32'(wr_ready),  32'(e.rdy));
        check("out_valid", 32'(out_valid), 32'(e.ov));
        check("idx_err",   32'(idx_err),   32'(e.ie));
        check("dup_err",   32'(dup_err),   32'(e.de));
        check("elem0", elem(vec_out, 0), e.e0);
        check("elem1", elem(vec_out, 1), e.e1);
        check("elem2", elem(vec_out, 2), e.e2);
        check("pad_bits", 32'(pad), 32'h0);
        wr_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; wr_valid = 1'b0; wr_indexed = 1'b0;
        seleccion = '0; d_in = '0; out_ready = 1'b0;

        // Sequential fill, hold in DONE, handshake
        tbl.push_back(mk(1,0,0,'hA, 0,0, 1,0,0,0, 'hA,0,0));
        tbl.push_back(mk(1,0,0,'hB, 0,0, 1,0,0,0, 'hA,'hB,0));
        tbl.push_back(mk(1,0,0,'hC, 0,0, 0,1,0,0, 'hA,'hB,'hC));
        tbl.push_back(mk(1,0,0,'hD, 0,0, 0,1,0,0, 'hA,'hB,'hC));
        tbl.push_back(mk(0,0,0,0,   0,1, 1,0,0,0, 'hA,'hB,'hC));
        // Indexed fill 2,0,1; write during DONE+out_ready is ignored
        tbl.push_back(mk(1,1,2,'h33, 0,0, 1,0,0,0, 'hA,'hB,'h33));
        tbl.push_back(mk(1,1,0,'h11, 0,0, 1,0,0,0, 'h11,'hB,'h33));
        tbl.push_back(mk(1,1,1,'h22, 0,0, 0,1,0,0, 'h11,'h22,'h33));
        tbl.push_back(mk(1,0,0,'h99, 0,1, 1,0,0,0, 'h11,'h22,'h33));
        // Out-of-range indexed writes
        tbl.push_back(mk(1,1,3,'hFF, 0,0, 1,0,1,0, 'h11,'h22,'h33));
        tbl.push_back(mk(0,0,0,0,    0,0, 1,0,0,0, 'h11,'h22,'h33));
        tbl.push_back(mk(1,1,32'hFFFF_FFFF,'hEE, 0,0, 1,0,1,0, 'h11,'h22,'h33));
        tbl.push_back(mk(0,0,0,0,    0,0, 1,0,0,0, 'h11,'h22,'h33));
        // Rewrite of element 0
        tbl.push_back(mk(1,1,0,'h1, 0,0, 1,0,0,0, 'h1,'h22,'h33));
        tbl.push_back(mk(1,1,0,'h2, 0,0, 1,0,0,1, 'h2,'h22,'h33));
        tbl.push_back(mk(0,0,0,0,   0,0, 1,0,0,0, 'h2,'h22,'h33));
        // Two writes then clear with a write; write dropped, pointer restarts
        tbl.push_back(mk(1,0,0,'h5, 0,0, 1,0,0,1, 'h5,'h22,'h33));
        tbl.push_back(mk(1,0,0,'h6, 0,0, 1,0,0,0, 'h5,'h6,'h33));
        tbl.push_back(mk(1,0,0,'h7, 1,0, 1,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,0,'h8, 0,0, 1,0,0,0, 'h8,0,0));
        tbl.push_back(mk(1,0,0,'h9, 0,0, 1,0,0,0, 'h8,'h9,0));
        tbl.push_back(mk(1,0,0,'hA, 0,0, 0,1,0,0, 'h8,'h9,'hA));
        tbl.push_back(mk(0,0,0,0,   1,1, 1,0,0,0, 0,0,0));
        // Indexed write leaves pointer alone
        tbl.push_back(mk(1,1,1,'h5, 0,0, 1,0,0,0, 0,'h5,0));
        tbl.push_back(mk(1,0,0,'h6, 0,0, 1,0,0,0, 'h6,'h5,0));
        tbl.push_back(mk(1,0,0,'h7, 0,0, 1,0,0,1, 'h6,'h7,0));
        tbl.push_back(mk(1,0,0,'h8, 0,0, 0,1,0,0, 'h6,'h7,'h8));
        tbl.push_back(mk(0,0,0,0,   0,1, 1,0,0,0, 'h6,'h7,'h8));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_vec_lo", 32'(vec_out[0:31]), 32'h0);
        check("rst_vec_all_zero", 32'(vec_out == '0), 32'h1);
        check("rst_wr_ready", 32'(wr_ready), 32'h1);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_idx_err", 32'(idx_err), 32'h0);
        check("rst_dup_err", 32'(dup_err), 32'h0);

        foreach (tbl[i]) drive(tbl[i]);

        // Asynchronous reset mid-fill
        drive(mk(1,0,0,'h1, 0,0, 1,0,0,0, 'h1,'h7,'h8));
        drive(mk(1,0,0,'h2, 0,0, 1,0,0,0, 'h1,'h2,'h8));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_vec_zero", 32'(vec_out == '0), 32'h1);
        check("async_out_valid", 32'(out_valid), 32'h0);
        check("async_wr_ready", 32'(wr_ready), 32'h1);
        #3;
        rst_n = 1'b1;
        drive(mk(1,0,0,'h44, 0,0, 1,0,0,0, 'h44,0,0));
        drive(mk(1,0,0,'h45, 0,0, 1,0,0,0, 'h44,'h45,0));

        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
